// File: rtl/mem_resp_pkg.sv
// Shared definitions for the system-bus memory responder.
// Holds the FSM state encoding, bus/map geometry and small field helpers.
// Bus words use MSB-first bit numbering: bus bit 0 is Verilog bit 15, so the
// page (bus bits 0..3) sits in ad[15:12] and the offset in ad[11:0].
package mem_resp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccept,
    StRamWait,
    StDone
  } state_e;

  localparam int unsigned WORD_BITS     = 16;
  localparam int unsigned SEG_BITS      = 4;
  localparam int unsigned SEG_COUNT     = 16;
  localparam int unsigned PAGE_BITS     = 4;
  localparam int unsigned OFFSET_BITS   = 12;
  localparam int unsigned MAP_ADDR_BITS = SEG_BITS + PAGE_BITS;
  localparam int unsigned MAP_ENTRIES   = SEG_COUNT << PAGE_BITS;

  // Config word: bus bit 0 (MSB) is the valid flag, the frame number is
  // right-aligned in the low bits.
  localparam int unsigned CFG_VALID_BIT = WORD_BITS - 1;

  function automatic logic [PAGE_BITS-1:0] page_of(input logic [WORD_BITS-1:0] ad);
    return ad[WORD_BITS-1 -: PAGE_BITS];
  endfunction

  function automatic logic [OFFSET_BITS-1:0] offset_of(input logic [WORD_BITS-1:0] ad);
    return ad[OFFSET_BITS-1:0];
  endfunction

  function automatic logic [MAP_ADDR_BITS-1:0] map_index(input logic [SEG_BITS-1:0]  seg,
                                                         input logic [PAGE_BITS-1:0] page);
    return {seg, page};
  endfunction

endpackage

// File: rtl/mem_resp_if.sv
// System-bus signal bundle between a memory-cycle initiator and a responder.
//   rq, wr, cfg, pn, q : request and qualifiers (initiator -> responder)
//   nb, ad, dt_in      : segment, word address, write/config data
//   dt_out, ok, pe     : read data and completion/refusal (responder -> initiator)
interface mem_resp_if;
  import mem_resp_pkg::*;

  logic                 rq;
  logic                 wr;
  logic                 cfg;
  logic                 pn;
  logic                 q;
  logic [SEG_BITS-1:0]  nb;
  logic [WORD_BITS-1:0] ad;
  logic [WORD_BITS-1:0] dt_in;
  logic [WORD_BITS-1:0] dt_out;
  logic                 ok;
  logic                 pe;

  modport master (
    output rq, wr, cfg, pn, q, nb, ad, dt_in,
    input  dt_out, ok, pe
  );

  modport slave (
    input  rq, wr, cfg, pn, q, nb, ad, dt_in,
    output dt_out, ok, pe
  );

endinterface

// File: rtl/mem_resp_seg_map.sv
// Segment map: 256 entries of {valid, frame}, indexed {segment, page}.
// One synchronous write port, one combinational read port.
//   clk_sys, rst          : clock, async active-high reset (invalidates all)
//   we, waddr, wvalid,
//   wframe                : write port
//   raddr, rvalid, rframe : read port
module seg_map
  import mem_resp_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 5
) (
  input  logic                     clk_sys,
  input  logic                     rst,
  input  logic                     we,
  input  logic [MAP_ADDR_BITS-1:0] waddr,
  input  logic                     wvalid,
  input  logic [FRAME_BITS-1:0]    wframe,
  input  logic [MAP_ADDR_BITS-1:0] raddr,
  output logic                     rvalid,
  output logic [FRAME_BITS-1:0]    rframe
);

  logic [MAP_ENTRIES-1:0] valid_q;
  logic [FRAME_BITS-1:0]  frame_q [MAP_ENTRIES];

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[waddr] <= wvalid;
    end
  end

  // Frames need no reset: they are only consumed when the valid bit is set.
  always_ff @(posedge clk_sys) begin
    if (we) begin
      frame_q[waddr] <= wframe;
    end
  end

  assign rvalid = valid_q[raddr];
  assign rframe = frame_q[raddr];

endmodule

// File: rtl/mem_resp.sv
// System-bus memory responder. Accepts cycles addressed to MEM_NUMBER,
// translates {segment, page} through seg_map to a physical frame and runs a
// fixed-latency cycle on the RAM port; answers ok, or pe for unmapped pages.
// Config cycles (cfg=1) load a map entry.
//   clk_sys, rst : clock, async active-high reset
//   bus          : system-bus slave side (rq/wr/cfg/pn/q/nb/ad/dt_in, dt_out/ok/pe)
//   mem_addr     : physical word address {frame, offset}
//   mem_we       : one-cycle RAM write strobe
//   mem_wdata    : RAM write data
//   mem_rdata    : RAM read data, valid MEM_LAT cycles after mem_addr is issued
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter logic        MEM_NUMBER = 1'b0,
  parameter int unsigned FRAME_BITS = 5,
  parameter int unsigned MEM_LAT    = 2
) (
  input  logic                              clk_sys,
  input  logic                              rst,
  mem_resp_if.slave                         bus,
  output logic [FRAME_BITS+OFFSET_BITS-1:0] mem_addr,
  output logic                              mem_we,
  output logic [WORD_BITS-1:0]              mem_wdata,
  input  logic [WORD_BITS-1:0]              mem_rdata
);

  localparam int unsigned ADDR_BITS = FRAME_BITS + OFFSET_BITS;
  localparam logic [2:0]  LAT_INIT  = 3'(MEM_LAT - 1);

  state_e                 state_q, state_d;
  logic                   rq_q;
  logic                   wr_q, cfg_q;
  logic [SEG_BITS-1:0]    seg_q, nb_q;
  logic [WORD_BITS-1:0]   ad_q, dt_q;
  logic [2:0]             cnt_q, cnt_d;
  logic                   ok_q, ok_d, pe_q, pe_d, we_q, we_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [WORD_BITS-1:0]   wdata_q, wdata_d, dout_q, dout_d;
  logic                   accept;
  logic                   map_we, map_rvalid;
  logic [FRAME_BITS-1:0]  map_rframe;

  // Only a fresh rising rq starts a cycle; rq_q resets high so a request held
  // across reset release is ignored.
  assign accept = (state_q == StIdle) && bus.rq && !rq_q && (bus.pn == MEM_NUMBER);

  seg_map #(
    .FRAME_BITS (FRAME_BITS)
  ) u_seg_map (
    .clk_sys (clk_sys),
    .rst     (rst),
    .we      (map_we),
    .waddr   (map_index(nb_q, page_of(ad_q))),
    .wvalid  (dt_q[CFG_VALID_BIT]),
    .wframe  (dt_q[FRAME_BITS-1:0]),
    .raddr   (map_index(seg_q, page_of(ad_q))),
    .rvalid  (map_rvalid),
    .rframe  (map_rframe)
  );

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    pe_d    = pe_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    map_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StAccept;
      end
      StAccept: begin
        if (cfg_q) begin
          map_we  = 1'b1;
          ok_d    = 1'b1;
          state_d = StDone;
        end else if (!map_rvalid) begin
          pe_d    = 1'b1;
          state_d = StDone;
        end else begin
          // Frame is captured here, so later map writes cannot disturb this cycle.
          addr_d = {map_rframe, offset_of(ad_q)};
          if (wr_q) begin
            we_d    = 1'b1;
            wdata_d = dt_q;
            ok_d    = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = StRamWait;
          end
        end
      end
      StRamWait: begin
        if (cnt_q == 3'd0) begin
          dout_d  = mem_rdata;
          ok_d    = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        if (!bus.rq) begin
          ok_d    = 1'b0;
          pe_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rq_q    <= 1'b1;
      wr_q    <= 1'b0;
      cfg_q   <= 1'b0;
      seg_q   <= '0;
      nb_q    <= '0;
      ad_q    <= '0;
      dt_q    <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      pe_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      rq_q <= bus.rq;
      if (accept) begin
        wr_q  <= bus.wr;
        cfg_q <= bus.cfg;
        seg_q <= bus.q ? bus.nb : '0;
        nb_q  <= bus.nb;
        ad_q  <= bus.ad;
        dt_q  <= bus.dt_in;
      end
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      pe_q    <= pe_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.ok     = ok_q;
  assign bus.pe     = pe_q;
  assign bus.dt_out = dout_q;
  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_wdata  = wdata_q;

endmodule
